// File: rtl/cosim_commit_queue.sv
// cosim_commit_queue: circular FIFO between the core's retire/trap stream and the
// co-simulation checker port. Each posedge at most one retire group is captured
// and at most one is replayed onto a registered checker bundle. in_ready gives
// the core SKID cycles of warning before the queue fills. A group pushed while
// the queue is full and not draining is dropped, and sets a sticky overflow flag.
// Build option: define COSIM_QUEUE_COMPACT_EN to pack the valid lanes of each
// group into lanes 0..n-1 before storage. Without it, lanes keep their positions.
module cosim_commit_queue #(
  parameter int COMMIT_WIDTH = 2,
  parameter int XLEN         = 64,
  parameter int DEPTH        = 8,
  parameter int SKID         = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [COMMIT_WIDTH-1:0]      in_valid,
  input  logic [31:0]                  in_hartid,
  input  logic [XLEN*COMMIT_WIDTH-1:0] in_pc,
  input  logic [32*COMMIT_WIDTH-1:0]   in_inst,
  input  logic [XLEN*COMMIT_WIDTH-1:0] in_wdata,
  input  logic [XLEN*COMMIT_WIDTH-1:0] in_mstatus,
  input  logic [COMMIT_WIDTH-1:0]      in_check,
  input  logic                         in_trap,
  input  logic [XLEN-1:0]              in_cause,
  output logic                         in_ready,
  input  logic                         out_ready,
  output logic [COMMIT_WIDTH-1:0]      valid,
  output logic [XLEN*COMMIT_WIDTH-1:0] pc,
  output logic [32*COMMIT_WIDTH-1:0]   inst,
  output logic [XLEN*COMMIT_WIDTH-1:0] wdata,
  output logic [XLEN*COMMIT_WIDTH-1:0] mstatus,
  output logic [COMMIT_WIDTH-1:0]      check,
  output logic                         int_xcpt,
  output logic [XLEN-1:0]              cause,
  output logic [31:0]                  hartid,
  output logic [$clog2(DEPTH):0]       occupancy,
  output logic                         overflow
);

  localparam int CW    = COMMIT_WIDTH;
  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W-1:0] RDY_MAX = PTR_W'(DEPTH - SKID - 1);

  // Storage. It is not reset, because the pointers alone define which entries are live.
  logic [CW-1:0]      mem_valid_r   [DEPTH];
  logic [XLEN*CW-1:0] mem_pc_r      [DEPTH];
  logic [32*CW-1:0]   mem_inst_r    [DEPTH];
  logic [XLEN*CW-1:0] mem_wdata_r   [DEPTH];
  logic [XLEN*CW-1:0] mem_mstatus_r [DEPTH];
  logic [CW-1:0]      mem_check_r   [DEPTH];
  logic               mem_trap_r    [DEPTH];
  logic [XLEN-1:0]    mem_cause_r   [DEPTH];

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] occ_next_s;
  logic             full_s;
  logic             empty_s;
  logic             pop_s;
  logic             push_req_s;
  logic             push_acc_s;

  // Lane image of the incoming group as it will be stored.
  logic [CW-1:0]      st_valid_s;
  logic [XLEN*CW-1:0] st_pc_s;
  logic [32*CW-1:0]   st_inst_s;
  logic [XLEN*CW-1:0] st_wdata_s;
  logic [XLEN*CW-1:0] st_mstatus_s;
  logic [CW-1:0]      st_check_s;
`ifdef COSIM_QUEUE_COMPACT_EN
  int                 idx_s;
`endif

  // Full means the wrap bits differ and the index bits match. Empty groups never request a push.
  always_comb begin
    full_s     = (wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]) &&
                 (wr_ptr_r[PTR_W-2:0] == rd_ptr_r[PTR_W-2:0]);
    empty_s    = (wr_ptr_r == rd_ptr_r);
    pop_s      = out_ready && !empty_s;
    push_req_s = (|in_valid) || in_trap;
    push_acc_s = push_req_s && (!full_s || pop_s);
    case ({push_acc_s, pop_s})
      2'b10:   occ_next_s = occupancy + PTR_ONE;
      2'b01:   occ_next_s = occupancy - PTR_ONE;
      default: occ_next_s = occupancy;
    endcase
  end

  // Shape the incoming lanes: either pack them low, or keep them in place with check masked by valid.
  always_comb begin
    st_valid_s   = '0;
    st_pc_s      = '0;
    st_inst_s    = '0;
    st_wdata_s   = '0;
    st_mstatus_s = '0;
    st_check_s   = '0;
`ifdef COSIM_QUEUE_COMPACT_EN
    idx_s = 0;
    for (int i = 0; i < CW; i++) begin
      if (in_valid[i]) begin
        st_valid_s[idx_s]                    = 1'b1;
        st_pc_s[idx_s*XLEN +: XLEN]          = in_pc[i*XLEN +: XLEN];
        st_inst_s[idx_s*32 +: 32]            = in_inst[i*32 +: 32];
        st_wdata_s[idx_s*XLEN +: XLEN]       = in_wdata[i*XLEN +: XLEN];
        st_mstatus_s[idx_s*XLEN +: XLEN]     = in_mstatus[i*XLEN +: XLEN];
        st_check_s[idx_s]                    = in_check[i];
        idx_s                                = idx_s + 1;
      end else begin
        idx_s = idx_s;
      end
    end
`else
    st_valid_s   = in_valid;
    st_pc_s      = in_pc;
    st_inst_s    = in_inst;
    st_wdata_s   = in_wdata;
    st_mstatus_s = in_mstatus;
    st_check_s   = in_check & in_valid;
`endif
  end

  // Write the accepted group into the tail slot.
  always_ff @(posedge clock) begin
    if (push_acc_s) begin
      mem_valid_r[wr_ptr_r[PTR_W-2:0]]   <= st_valid_s;
      mem_pc_r[wr_ptr_r[PTR_W-2:0]]      <= st_pc_s;
      mem_inst_r[wr_ptr_r[PTR_W-2:0]]    <= st_inst_s;
      mem_wdata_r[wr_ptr_r[PTR_W-2:0]]   <= st_wdata_s;
      mem_mstatus_r[wr_ptr_r[PTR_W-2:0]] <= st_mstatus_s;
      mem_check_r[wr_ptr_r[PTR_W-2:0]]   <= st_check_s;
      mem_trap_r[wr_ptr_r[PTR_W-2:0]]    <= in_trap;
      mem_cause_r[wr_ptr_r[PTR_W-2:0]]   <= in_cause;
    end
  end

  // Pointers, occupancy, sticky overflow and the early-warning ready flag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      occupancy <= '0;
      overflow  <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      if (push_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (push_req_s && !push_acc_s) begin
        overflow <= 1'b1;
      end
      occupancy <= occ_next_s;
      in_ready  <= (occ_next_s <= RDY_MAX);
    end
  end

  // Checker bundle: valid/int_xcpt pulse for one cycle per pop, data fields hold between pops.
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid    <= '0;
      pc       <= '0;
      inst     <= '0;
      wdata    <= '0;
      mstatus  <= '0;
      check    <= '0;
      int_xcpt <= 1'b0;
      cause    <= '0;
      hartid   <= 32'h0000_0000;
    end else begin
      hartid <= in_hartid;
      if (pop_s) begin
        valid    <= mem_valid_r[rd_ptr_r[PTR_W-2:0]];
        pc       <= mem_pc_r[rd_ptr_r[PTR_W-2:0]];
        inst     <= mem_inst_r[rd_ptr_r[PTR_W-2:0]];
        wdata    <= mem_wdata_r[rd_ptr_r[PTR_W-2:0]];
        mstatus  <= mem_mstatus_r[rd_ptr_r[PTR_W-2:0]];
        check    <= mem_check_r[rd_ptr_r[PTR_W-2:0]];
        int_xcpt <= mem_trap_r[rd_ptr_r[PTR_W-2:0]];
        cause    <= mem_cause_r[rd_ptr_r[PTR_W-2:0]];
      end else begin
        valid    <= '0;
        int_xcpt <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cosim_commit_queue.sv
// Scoreboard bench for cosim_commit_queue (COMMIT_WIDTH=2, XLEN=64, DEPTH=8, SKID=2).
// The reference is a bounded queue of whole groups. Each popped group is queued
// as the expected output, and a monitor compares it when the DUT emits a group.
// Follows COSIM_QUEUE_COMPACT_EN in the same way as the design.
module tb_cosim_commit_queue;

  localparam int DEPTH = 8;
  localparam int SKID  = 2;

  typedef struct packed {
    logic [1:0]   v;
    logic [127:0] pc;
    logic [63:0]  inst;
    logic [127:0] wd;
    logic [127:0] ms;
    logic [1:0]   ck;
    logic         tr;
    logic [63:0]  cause;
  } grp_t;

  logic         clock;
  logic         reset;
  logic [1:0]   in_valid;
  logic [31:0]  in_hartid;
  logic [127:0] in_pc;
  logic [63:0]  in_inst;
  logic [127:0] in_wdata;
  logic [127:0] in_mstatus;
  logic [1:0]   in_check;
  logic         in_trap;
  logic [63:0]  in_cause;
  logic         in_ready;
  logic         out_ready;
  logic [1:0]   valid;
  logic [127:0] pc;
  logic [63:0]  inst;
  logic [127:0] wdata;
  logic [127:0] mstatus;
  logic [1:0]   check;
  logic         int_xcpt;
  logic [63:0]  cause;
  logic [31:0]  hartid;
  logic [3:0]   occupancy;
  logic         overflow;

  cosim_commit_queue #(.COMMIT_WIDTH(2), .XLEN(64), .DEPTH(DEPTH), .SKID(SKID)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_hartid(in_hartid),
    .in_pc(in_pc), .in_inst(in_inst), .in_wdata(in_wdata), .in_mstatus(in_mstatus),
    .in_check(in_check), .in_trap(in_trap), .in_cause(in_cause), .in_ready(in_ready),
    .out_ready(out_ready), .valid(valid), .pc(pc), .inst(inst), .wdata(wdata),
    .mstatus(mstatus), .check(check), .int_xcpt(int_xcpt), .cause(cause),
    .hartid(hartid), .occupancy(occupancy), .overflow(overflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int   vectors = 0;
  int   miscompares = 0;
  grp_t mq[$];      // model FIFO contents
  grp_t exp_q[$];   // groups the checker port should emit, in order
  grp_t last_g;     // data fields currently held on the outputs
  logic ovf_m;
  logic rdy_m;
  logic [31:0] hart_m;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Build the group the queue should store from the current inputs.
  function automatic grp_t make_grp();
    grp_t g;
    int   lanes[$];
    g = '0;
    g.tr    = in_trap;
    g.cause = in_cause;
`ifdef COSIM_QUEUE_COMPACT_EN
    for (int i = 0; i < 2; i++) if (in_valid[i]) lanes.push_back(i);
    foreach (lanes[k]) begin
      g.v[k]              = 1'b1;
      g.pc[k*64 +: 64]    = in_pc[lanes[k]*64 +: 64];
      g.inst[k*32 +: 32]  = in_inst[lanes[k]*32 +: 32];
      g.wd[k*64 +: 64]    = in_wdata[lanes[k]*64 +: 64];
      g.ms[k*64 +: 64]    = in_mstatus[lanes[k]*64 +: 64];
      g.ck[k]             = in_check[lanes[k]];
    end
`else
    lanes.push_back(0);
    g.v  = in_valid;
    g.pc = in_pc;
    g.inst = in_inst;
    g.wd = in_wdata;
    g.ms = in_mstatus;
    for (int i = 0; i < 2; i++) g.ck[i] = in_valid[i] ? in_check[i] : 1'b0;
`endif
    return g;
  endfunction

  task automatic rand_data();
    in_pc      = {$urandom, $urandom, $urandom, $urandom};
    in_inst    = {$urandom, $urandom};
    in_wdata   = {$urandom, $urandom, $urandom, $urandom};
    in_mstatus = {$urandom, $urandom, $urandom, $urandom};
    in_check   = 2'($urandom);
    in_cause   = {$urandom, $urandom};
  endtask

  // Predict the coming posedge from the inputs that are driven now, then check the visible state afterwards.
  task automatic step(input logic rst);
    grp_t g;
    reset = rst;
    if (!rst) begin
      mq.delete();
      ovf_m  = 1'b0;
      rdy_m  = 1'b1;
      hart_m = 32'h0;
      last_g = '0;
    end else begin
      if (out_ready && mq.size() != 0) begin
        g = mq.pop_front();
        exp_q.push_back(g);
        last_g = g;
      end
      if ((|in_valid) || in_trap) begin
        if (mq.size() < DEPTH) mq.push_back(make_grp());
        else ovf_m = 1'b1;
      end
      hart_m = in_hartid;
      rdy_m  = (mq.size() <= DEPTH - SKID - 1);
    end
    @(negedge clock);
    chk("occupancy", 128'(occupancy), 128'(mq.size()));
    chk("in_ready", 128'(in_ready), 128'(rdy_m));
    chk("overflow", 128'(overflow), 128'(ovf_m));
    chk("hartid", 128'(hartid), 128'(hart_m));
    chk("held_pc", pc, last_g.pc);
    chk("held_cause", 128'(cause), 128'(last_g.cause));
    if (!rst) begin
      chk("rst_valid", 128'(valid), 128'(2'b00));
      chk("rst_int_xcpt", 128'(int_xcpt), 128'(1'b0));
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    in_valid  = 2'b00;
    in_trap   = 1'b0;
    out_ready = ordy;
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  // Monitor: every group the checker port presents must be the next expected one.
  always @(negedge clock) begin
    grp_t e;
    if (valid !== 2'b00 || int_xcpt !== 1'b0) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_group actual valid=%b int_xcpt=%b pc=%h expected none at %0t",
                 valid, int_xcpt, pc, $time);
      end else begin
        e = exp_q.pop_front();
        chk("out_valid", 128'(valid), 128'(e.v));
        chk("out_pc", pc, e.pc);
        chk("out_inst", 128'(inst), 128'(e.inst));
        chk("out_wdata", wdata, e.wd);
        chk("out_mstatus", mstatus, e.ms);
        chk("out_check", 128'(check), 128'(e.ck));
        chk("out_int_xcpt", 128'(int_xcpt), 128'(e.tr));
        chk("out_cause", 128'(cause), 128'(e.cause));
      end
    end
  end

  initial begin
    in_hartid = 32'h0000_0003;
    in_trap   = 1'b0;
    out_ready = 1'b0;
    rand_data();

    // Reset held with lanes asserted: nothing may be captured.
    in_valid = 2'b11;
    for (int i = 0; i < 3; i++) step(1'b0);

    // Single two-lane group with an open checker.
    in_pc = {64'h0000_0000_8000_0004, 64'h0000_0000_8000_0000};
    in_valid  = 2'b11;
    out_ready = 1'b1;
    step(1'b1);
    idle(3, 1'b1);

    // Stalled checker: fill past capacity, expect early ready drop and one dropped group.
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      rand_data();
      in_valid = 2'($urandom_range(1, 3));
      step(1'b1);
    end
    chk("full_occupancy", 128'(occupancy), 128'(4'd8));
    chk("full_overflow", 128'(overflow), 128'(1'b1));
    idle(10, 1'b1);

    // Trap with one retired lane.
    rand_data();
    in_valid = 2'b01;
    in_trap  = 1'b1;
    in_cause = 64'h8000_0000_0000_0007;
    step(1'b1);
    idle(3, 1'b1);

    // Upper lane only: compaction moves it to lane 0.
    rand_data();
    in_valid = 2'b10;
    in_pc[127:64] = 64'h0000_0000_8000_0010;
    step(1'b1);
    idle(3, 1'b1);

    // Full queue with push+pop at full rate across the pointer wrap, then reset mid-stream.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rand_data();
      in_valid = 2'($urandom_range(1, 3));
      step(1'b1);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_data();
      in_valid = 2'($urandom_range(0, 3));
      in_trap  = (in_valid == 2'b00) ? 1'b1 : 1'($urandom_range(0, 1));
      step(1'b1);
    end
    for (int i = 0; i < 2; i++) begin
      rand_data();
      in_valid = 2'b11;
      step(1'b0);
    end
    in_trap = 1'b0;
    idle(4, 1'b1);

    // Random traffic, including empty cycles and checker stalls.
    for (int i = 0; i < 400; i++) begin
      rand_data();
      in_valid  = 2'($urandom_range(0, 3));
      in_trap   = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      step(($urandom_range(0, 150) == 0) ? 1'b0 : 1'b1);
    end

    // Drain everything, with a bound on the number of cycles.
    in_valid  = 2'b00;
    in_trap   = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && mq.size() != 0; i++) step(1'b1);
    idle(3, 1'b1);
    chk("drained_model", 128'(mq.size()), 128'(0));
    chk("all_groups_seen", 128'(exp_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
